// File: rtl/wall_motion_controller.sv
// Falling-wall sequencer: owns the wall position, visibility, lives and respawn column.
// Every output comes straight from a register, so each one has exactly one cycle of latency.
module wall_motion_controller #(
   parameter int SCREEN_H     = 480,
   parameter int OBJ_H        = 100,
   parameter int INIT_X       = 270,
   parameter int X_MAX        = 540,
   parameter int PAUSE_FRAMES = 30,
   parameter int LIVES        = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               start,
   input  logic               collision,
   input  logic [3:0]         speed,
   output logic signed [10:0] topLeftX,
   output logic signed [10:0] topLeftY,
   output logic               visible,
   output logic               wallPassed,
   output logic [2:0]         livesLeft,
   output logic               gameOver
);

   typedef enum logic [1:0] {IDLE, FALL, HIT, GAME_OVER} state_t;

   localparam int                 PW          = $clog2(PAUSE_FRAMES + 1);
   localparam logic signed [10:0] C_RESPAWN_Y = 11'(-OBJ_H);
   localparam logic signed [10:0] C_INIT_X    = 11'(INIT_X);
   localparam logic signed [11:0] C_SCREEN_H  = 12'(SCREEN_H);
   localparam logic [10:0]        C_X_MAX     = 11'(X_MAX);
   localparam logic [10:0]        C_X_WRAP    = 11'(X_MAX + 1);
   localparam logic [PW-1:0]      C_PAUSE_END = PW'(PAUSE_FRAMES - 1);
   localparam logic [2:0]         C_LIVES     = 3'(LIVES);

   state_t               r_state;
   logic signed [10:0]   r_x;
   logic signed [10:0]   r_y;
   logic                 r_visible;
   logic                 r_passed;
   logic [2:0]           r_lives;
   logic                 r_over;
   logic [PW-1:0]        r_pause;
   logic [8:0]           r_lfsr;

   logic                 w_lfsr_fb;
   logic [10:0]          w_lfsr_ext;
   logic signed [10:0]   w_new_x;
   logic signed [11:0]   w_sum;

   // Taps for x^9 + x^5 + 1; the nonzero seed keeps the register out of the all-zero lockup.
   assign w_lfsr_fb  = r_lfsr[8] ^ r_lfsr[4];
   assign w_lfsr_ext = {2'b00, r_lfsr};
   assign w_sum      = {r_y[10], r_y} + {8'd0, speed};

   always_comb begin
      // NOTE: assign a default first so every path drives w_new_x and no latch is inferred.
      w_new_x = w_lfsr_ext;
      if (w_lfsr_ext > C_X_MAX) begin
         w_new_x = w_lfsr_ext - C_X_WRAP;
      end
   end

   // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= IDLE;
         r_x       <= C_INIT_X;
         r_y       <= C_RESPAWN_Y;
         r_visible <= 1'b0;
         r_passed  <= 1'b0;
         r_lives   <= C_LIVES;
         r_over    <= 1'b0;
         r_pause   <= '0;
         r_lfsr    <= 9'h1A5;
      end else begin
         r_lfsr   <= {r_lfsr[7:0], w_lfsr_fb};
         r_passed <= 1'b0;
         case (r_state)
            IDLE, GAME_OVER: begin
               if (start) begin
                  r_state   <= FALL;
                  r_x       <= C_INIT_X;
                  r_y       <= C_RESPAWN_Y;
                  r_lives   <= C_LIVES;
                  r_visible <= 1'b1;
                  r_over    <= 1'b0;
               end
            end
            FALL: begin
               // A hit wins over movement even when both land in the same cycle.
               if (collision) begin
                  r_state <= HIT;
                  r_pause <= '0;
                  if (r_lives != 3'd0) begin
                     r_lives <= r_lives - 3'd1;
                  end
               end else if (startOfFrame) begin
                  if (w_sum >= C_SCREEN_H) begin
                     r_y      <= C_RESPAWN_Y;
                     r_x      <= w_new_x;
                     r_passed <= 1'b1;
                  end else begin
                     r_y <= w_sum[10:0];
                  end
               end
            end
            HIT: begin
               if (startOfFrame) begin
                  if (r_pause == C_PAUSE_END) begin
                     if (r_lives == 3'd0) begin
                        r_state   <= GAME_OVER;
                        r_visible <= 1'b0;
                        r_over    <= 1'b1;
                     end else begin
                        r_state <= FALL;
                        r_y     <= C_RESPAWN_Y;
                        r_x     <= w_new_x;
                     end
                  end else begin
                     r_pause <= r_pause + 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign topLeftX   = r_x;
   assign topLeftY   = r_y;
   assign visible    = r_visible;
   assign wallPassed = r_passed;
   assign livesLeft  = r_lives;
   assign gameOver   = r_over;

endmodule
